// File: rtl/frame_sequencer.sv
// frame_sequencer
//   Audio frame counter sequencer. It advances one step per 240 Hz tick and emits
//   quarter-frame and half-frame clocks in 4-step or 5-step mode. It also raises
//   the frame IRQ and applies delayed CPU mode writes. Each applied write pulses
//   frame_sync so that the upstream prescaler can realign.
//   Optional feature macro: FRAME_IRQ_EN. When it is defined, the frame IRQ flop
//   and its set/clear logic are built. When it is undefined, frame_irq is tied low.

module frame_sequencer #(
  parameter int WRITE_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_240hz,
  input  logic       cfg_we,
  input  logic       cfg_mode,
  input  logic       cfg_irq_inhibit,
  input  logic       irq_ack,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       frame_sync,
  output logic [2:0] step
);

  localparam logic [2:0] STEP_0 = 3'd0;
  localparam logic [2:0] STEP_1 = 3'd1;
  localparam logic [2:0] STEP_2 = 3'd2;
  localparam logic [2:0] STEP_3 = 3'd3;
  localparam logic [2:0] STEP_4 = 3'd4;

  localparam logic [2:0] DELAY_LOAD = 3'(WRITE_DELAY);

  logic       mode;
  logic       pend_mode;
  logic       pending;
  logic [2:0] delay_cnt;

  logic       apply;
  logic [2:0] step_next;
  logic       tick_qf;
  logic       tick_hf;
  logic       irq_set;

  // Decode the apply cycle, plus the pulses and next step that a tick at the current step would produce
  always_comb begin
    apply     = pending && (delay_cnt == 3'd1) && !cfg_we;
    step_next = STEP_0;
    tick_qf   = 1'b0;
    tick_hf   = 1'b0;
    irq_set   = 1'b0;
    if (mode) begin
      case (step)
        STEP_0: begin tick_qf = 1'b1; step_next = STEP_1; end
        STEP_1: begin tick_qf = 1'b1; tick_hf = 1'b1; step_next = STEP_2; end
        STEP_2: begin tick_qf = 1'b1; step_next = STEP_3; end
        STEP_3: begin step_next = STEP_4; end
        STEP_4: begin tick_qf = 1'b1; tick_hf = 1'b1; step_next = STEP_0; end
        default: step_next = STEP_0;
      endcase
    end else begin
      case (step)
        STEP_0: begin tick_qf = 1'b1; step_next = STEP_1; end
        STEP_1: begin tick_qf = 1'b1; tick_hf = 1'b1; step_next = STEP_2; end
        STEP_2: begin tick_qf = 1'b1; step_next = STEP_3; end
        STEP_3: begin tick_qf = 1'b1; tick_hf = 1'b1; irq_set = 1'b1; step_next = STEP_0; end
        default: step_next = STEP_0;
      endcase
    end
  end

  // Step register and registered pulses; an applying write takes priority over a tick and drops it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step          <= STEP_0;
      mode          <= 1'b0;
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_sync    <= 1'b0;
    end else begin
      quarter_frame <= 1'b0;
      half_frame    <= 1'b0;
      frame_sync    <= 1'b0;
      if (apply) begin
        mode          <= pend_mode;
        step          <= STEP_0;
        frame_sync    <= 1'b1;
        quarter_frame <= pend_mode;
        half_frame    <= pend_mode;
      end else if (tick_240hz) begin
        step          <= step_next;
        quarter_frame <= tick_qf;
        half_frame    <= tick_hf;
      end
    end
  end

  // Hold a written mode for WRITE_DELAY cycles; a new write overwrites it and restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_mode <= 1'b0;
      pending   <= 1'b0;
      delay_cnt <= 3'd0;
    end else if (cfg_we) begin
      pend_mode <= cfg_mode;
      pending   <= 1'b1;
      delay_cnt <= DELAY_LOAD;
    end else if (pending) begin
      if (apply) begin
        pending   <= 1'b0;
        delay_cnt <= 3'd0;
      end else begin
        delay_cnt <= delay_cnt - 3'd1;
      end
    end
  end

`ifdef FRAME_IRQ_EN
  logic inhibit;
  logic pend_inhibit;

  // Inhibit follows the same delayed-write path as mode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_inhibit <= 1'b0;
      inhibit      <= 1'b0;
    end else begin
      if (cfg_we) begin
        pend_inhibit <= cfg_irq_inhibit;
      end
      if (apply) begin
        inhibit <= pend_inhibit;
      end
    end
  end

  // Frame IRQ: an inhibit write clears it at once, a step-3 tick sets it, and an ack clears it otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_irq <= 1'b0;
    end else if (cfg_we && cfg_irq_inhibit) begin
      frame_irq <= 1'b0;
    end else if (tick_240hz && !apply && irq_set && !inhibit) begin
      frame_irq <= 1'b1;
    end else if (irq_ack) begin
      frame_irq <= 1'b0;
    end
  end
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = irq_ack ^ cfg_irq_inhibit ^ irq_set;
  assign frame_irq         = 1'b0;
`endif

endmodule
